// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR sequencer slice.
//   - fir_state_e     : sequencer FSM encoding
//   - TAP_MAX         : default maximum tap count (data-RAM depth)
//   - AP_*_BIT        : bit positions inside the ap_ctrl register
//   - REG_*           : AXI-Lite register offsets owned by the register block
//   - clamp_taps()    : maps the programmed tap count onto 1..tap_max
package fir_pkg;

    localparam int unsigned TAP_MAX = 32;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StInit  = 3'd1,
        StWaitX = 3'd2,
        StCalc  = 3'd3,
        StDrain = 3'd4,
        StOut   = 3'd5
    } fir_state_e;

    localparam int unsigned AP_START_BIT = 0;
    localparam int unsigned AP_DONE_BIT  = 1;
    localparam int unsigned AP_IDLE_BIT  = 2;

    localparam logic [11:0] REG_AP_CTRL  = 12'h000;
    localparam logic [11:0] REG_DATA_LEN = 12'h010;
    localparam logic [11:0] REG_TAP_NUM  = 12'h014;
    localparam logic [11:0] REG_TAP_BASE = 12'h080;

    // Zero taps would leave the sequencer with nothing to iterate over, so treat it as one.
    function automatic int unsigned clamp_taps(input logic [5:0] tap_num,
                                               input int unsigned tap_max);
        if (tap_num == '0) return 1;
        if (32'(tap_num) > tap_max) return tap_max;
        return 32'(tap_num);
    endfunction

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// fir_seq_ctrl_if: bundle of every non-clock signal of the FIR sequencer.
//   master : sequencer view (drives lifecycle flags, stream readies/valids, RAM and MAC controls)
//   slave  : surrounding view (register block, streams, RAMs, datapath)
// Signals: ap_start/done_clr/tap_num/data_length (config in), ap_idle/ap_done/cfg_lock (status),
//          ss_* (sample stream in), sm_* (result stream out), tap_*/data_* (BRAM ports),
//          mac_vld/mac_first (datapath controls).
interface fir_seq_ctrl_if #(
    parameter int unsigned pADDR_WIDTH = 12
) ();

    logic                   ap_start;
    logic                   done_clr;
    logic [5:0]             tap_num;
    logic [31:0]            data_length;
    logic                   ap_idle;
    logic                   ap_done;
    logic                   cfg_lock;
    logic                   ss_tvalid;
    logic                   ss_tready;
    logic                   sm_tvalid;
    logic                   sm_tready;
    logic                   sm_tlast;
    logic                   tap_EN;
    logic [pADDR_WIDTH-1:0] tap_A;
    logic                   data_EN;
    logic [3:0]             data_WE;
    logic [pADDR_WIDTH-1:0] data_A;
    logic                   data_Di_sel;
    logic                   mac_vld;
    logic                   mac_first;

    modport master (
        input  ap_start, done_clr, tap_num, data_length, ss_tvalid, sm_tready,
        output ap_idle, ap_done, cfg_lock, ss_tready, sm_tvalid, sm_tlast,
        output tap_EN, tap_A, data_EN, data_WE, data_A, data_Di_sel, mac_vld, mac_first
    );

    modport slave (
        output ap_start, done_clr, tap_num, data_length, ss_tvalid, sm_tready,
        input  ap_idle, ap_done, cfg_lock, ss_tready, sm_tvalid, sm_tlast,
        input  tap_EN, tap_A, data_EN, data_WE, data_A, data_Di_sel, mac_vld, mac_first
    );

endinterface

// File: rtl/fir_mod_cnt.sv
// fir_mod_cnt: modulo-(i_max+1) up/down counter with synchronous load.
//   clk, rst    : clock, synchronous active-high reset (count -> 0)
//   i_max       : largest count value; stepping past it wraps to 0, stepping below 0 wraps to it
//   i_load      : load i_load_val (priority over counting)
//   i_inc/i_dec : count up / down (inc wins if both set)
//   o_cnt       : current count
module fir_mod_cnt #(
    parameter int unsigned Width = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] i_max,
    input  logic             i_load,
    input  logic [Width-1:0] i_load_val,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [Width-1:0] o_cnt
);

    logic [Width-1:0] r_cnt;
    logic [Width-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_load) begin
            w_cnt_nxt = i_load_val;
        end else if (i_inc) begin
            w_cnt_nxt = (r_cnt == i_max) ? '0 : r_cnt + Width'(1);
        end else if (i_dec) begin
            w_cnt_nxt = (r_cnt == '0) ? i_max : r_cnt - Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: FIR core sequencer. Runs the ap_start/ap_done/ap_idle lifecycle, zeroes the
// data RAM, keeps the circular sample buffer, issues tap/data RAM reads per output and drives
// the MAC controls through a pMAC_LAT-deep tag pipeline; handshakes both AXI streams.
//   axis_clk : clock
//   axis_rst : synchronous active-high reset (aborts any operation)
//   bus      : fir_seq_ctrl_if master view (config, status, streams, RAM ports, MAC controls)
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pTAP_MAX    = TAP_MAX,
    parameter int unsigned pMAC_LAT    = 2
) (
    input  logic           axis_clk,
    input  logic           axis_rst,
    fir_seq_ctrl_if.master bus
);

    localparam int unsigned IdxW   = $clog2(pTAP_MAX);
    localparam int unsigned DrainW = $clog2(pMAC_LAT + 1);

    fir_state_e          r_state, w_state_nxt;
    logic [IdxW-1:0]     r_last;       // N-1
    logic [31:0]         r_len;
    logic [31:0]         r_y_cnt;
    logic                r_done;
    logic [pMAC_LAT-1:0] r_tag_vld, r_tag_first;
    logic [DrainW-1:0]   r_drain;

    logic [IdxW-1:0] w_last_nxt, w_idx, w_wptr, w_rd;
    logic w_idx_load, w_idx_inc, w_wptr_load, w_wptr_inc, w_rd_load, w_rd_dec;
    logic w_init_end, w_out_hs, w_set_done, w_tag_vld, w_tag_first;

    function automatic logic [pADDR_WIDTH-1:0] idx_addr(input logic [IdxW-1:0] idx);
        return pADDR_WIDTH'({idx, 2'b00});
    endfunction

    assign w_last_nxt = IdxW'(clamp_taps(bus.tap_num, pTAP_MAX) - 1);

    // i during INIT, k during CALC
    fir_mod_cnt #(.Width(IdxW)) u_idx (
        .clk(axis_clk), .rst(axis_rst), .i_max(r_last), .i_load(w_idx_load),
        .i_load_val('0), .i_inc(w_idx_inc), .i_dec(1'b0), .o_cnt(w_idx)
    );

    fir_mod_cnt #(.Width(IdxW)) u_wptr (
        .clk(axis_clk), .rst(axis_rst), .i_max(r_last), .i_load(w_wptr_load),
        .i_load_val('0), .i_inc(w_wptr_inc), .i_dec(1'b0), .o_cnt(w_wptr)
    );

    // Walks (wptr - k) mod N: newest sample first, wrapping 0 -> N-1.
    fir_mod_cnt #(.Width(IdxW)) u_rd (
        .clk(axis_clk), .rst(axis_rst), .i_max(r_last), .i_load(w_rd_load),
        .i_load_val(w_wptr), .i_inc(1'b0), .i_dec(w_rd_dec), .o_cnt(w_rd)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_load      = 1'b0;
        w_idx_inc       = 1'b0;
        w_wptr_load     = 1'b0;
        w_wptr_inc      = 1'b0;
        w_rd_load       = 1'b0;
        w_rd_dec        = 1'b0;
        w_init_end      = 1'b0;
        w_out_hs        = 1'b0;
        w_set_done      = 1'b0;
        w_tag_vld       = 1'b0;
        w_tag_first     = 1'b0;
        bus.ss_tready   = 1'b0;
        bus.sm_tvalid   = 1'b0;
        bus.sm_tlast    = 1'b0;
        bus.tap_EN      = 1'b0;
        bus.tap_A       = '0;
        bus.data_EN     = 1'b0;
        bus.data_WE     = 4'h0;
        bus.data_A      = '0;
        bus.data_Di_sel = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus.ap_start) begin
                    w_idx_load  = 1'b1;
                    w_state_nxt = StInit;
                end
            end
            StInit: begin
                bus.data_EN = 1'b1;
                bus.data_WE = 4'hF;
                bus.data_A  = idx_addr(w_idx);
                w_idx_inc   = 1'b1;
                if (w_idx == r_last) begin
                    w_init_end  = 1'b1;
                    w_wptr_load = 1'b1;
                    if (r_len == '0) begin
                        w_set_done  = 1'b1;
                        w_state_nxt = StIdle;
                    end else begin
                        w_state_nxt = StWaitX;
                    end
                end
            end
            StWaitX: begin
                bus.ss_tready = 1'b1;
                if (bus.ss_tvalid) begin
                    bus.data_EN     = 1'b1;
                    bus.data_WE     = 4'hF;
                    bus.data_Di_sel = 1'b1;
                    bus.data_A      = idx_addr(w_wptr);
                    w_rd_load       = 1'b1;
                    w_idx_load      = 1'b1;
                    w_state_nxt     = StCalc;
                end
            end
            StCalc: begin
                bus.tap_EN  = 1'b1;
                bus.data_EN = 1'b1;
                bus.tap_A   = idx_addr(w_idx);
                bus.data_A  = idx_addr(w_rd);
                w_tag_vld   = 1'b1;
                w_tag_first = (w_idx == '0);
                w_idx_inc   = 1'b1;
                w_rd_dec    = 1'b1;
                if (w_idx == r_last) w_state_nxt = StDrain;
            end
            StDrain: begin
                if (r_drain == DrainW'(pMAC_LAT - 1)) w_state_nxt = StOut;
            end
            StOut: begin
                bus.sm_tvalid = 1'b1;
                bus.sm_tlast  = (r_y_cnt == r_len - 32'd1);
                if (bus.sm_tready) begin
                    w_out_hs   = 1'b1;
                    w_wptr_inc = 1'b1;
                    if (bus.sm_tlast) begin
                        w_set_done  = 1'b1;
                        w_state_nxt = StIdle;
                    end else begin
                        w_state_nxt = StWaitX;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_state     <= StIdle;
            r_last      <= '0;
            r_len       <= '0;
            r_y_cnt     <= '0;
            r_done      <= 1'b0;
            r_tag_vld   <= '0;
            r_tag_first <= '0;
            r_drain     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == StIdle && bus.ap_start) begin
                r_last <= w_last_nxt;
                r_len  <= bus.data_length;
            end
            if (w_init_end) begin
                r_y_cnt <= '0;
            end else if (w_out_hs) begin
                r_y_cnt <= r_y_cnt + 32'd1;
            end
            // Completion beats a simultaneous host clear so no finish is ever lost.
            if (w_set_done) begin
                r_done <= 1'b1;
            end else if (bus.done_clr) begin
                r_done <= 1'b0;
            end
            r_tag_vld   <= (r_tag_vld << 1) | pMAC_LAT'(w_tag_vld);
            r_tag_first <= (r_tag_first << 1) | pMAC_LAT'(w_tag_first);
            r_drain     <= (r_state == StDrain) ? r_drain + DrainW'(1) : '0;
        end
    end

    assign bus.ap_idle   = (r_state == StIdle);
    assign bus.cfg_lock  = (r_state != StIdle);
    assign bus.ap_done   = r_done;
    assign bus.mac_vld   = r_tag_vld[pMAC_LAT-1];
    assign bus.mac_first = r_tag_first[pMAC_LAT-1];

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: directed bench for fir_seq_ctrl. Expected read addresses and tlast flags are
// queued when a sample is driven and popped as the sequencer produces them.
module tb_fir_seq_ctrl;

    localparam int AW  = 12;
    localparam int LAT = 2;

    typedef struct {
        int tap_a;
        int data_a;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_seq_ctrl_if #(.pADDR_WIDTH(AW)) bus ();

    fir_seq_ctrl #(.pADDR_WIDTH(AW), .pTAP_MAX(32), .pMAC_LAT(LAT)) dut (
        .axis_clk(clk),
        .axis_rst(rst),
        .bus     (bus)
    );

    int  n_checks = 0;
    int  n_pass   = 0;
    int  m_n, m_l, m_wptr, m_sent, m_done;
    rd_t exp_q[$];
    int  exp_last_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int clamp_n(input int t);
        if (t == 0) return 1;
        if (t > 32) return 32;
        return t;
    endfunction

    task automatic start_run(input int tap, input int len);
        bus.ap_start    = 1'b1;
        bus.tap_num     = 6'(tap);
        bus.data_length = 32'(len);
        tick();
        bus.ap_start = 1'b0;
        m_n    = clamp_n(tap);
        m_l    = len;
        m_sent = 0;
        check("start_idle", 32'(bus.ap_idle), 0);
        check("start_lock", 32'(bus.cfg_lock), 1);
        check("start_done_kept", 32'(bus.ap_done), m_done);
    endtask

    task automatic run_init(input bit clr_at0);
        for (int i = 0; i < m_n; i++) begin
            if (clr_at0 && i == 0) bus.done_clr = 1'b1;
            #1;
            check("init_en", 32'(bus.data_EN), 1);
            check("init_we", 32'(bus.data_WE), 'hF);
            check("init_sel", 32'(bus.data_Di_sel), 0);
            check("init_addr", 32'(bus.data_A), 4 * i);
            tick();
            bus.done_clr = 1'b0;
            if (clr_at0 && i == 0 && m_n > 1) begin
                m_done = 0;
                check("done_clr", 32'(bus.ap_done), 0);
            end
        end
        m_wptr = 0;
        #1;
        if (m_l == 0) begin
            m_done = 1;
            check("init_only_idle", 32'(bus.ap_idle), 1);
            check("init_only_done", 32'(bus.ap_done), 1);
            check("init_only_nobeat", 32'(bus.sm_tvalid), 0);
        end else begin
            check("waitx_ready", 32'(bus.ss_tready), 1);
            check("waitx_busy", 32'(bus.ap_idle), 0);
        end
    endtask

    task automatic send_sample(input int poke_at, input int abort_at, input bit early_rdy);
        int  waited = 0;
        rd_t e;
        while (bus.ss_tready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        check("ss_tready_wait", 32'(bus.ss_tready), 1);
        if (bus.ss_tready !== 1'b1) return;
        bus.ss_tvalid = 1'b1;
        if (early_rdy) bus.sm_tready = 1'b1;
        #1;
        check("wr_en", 32'(bus.data_EN), 1);
        check("wr_we", 32'(bus.data_WE), 'hF);
        check("wr_sel", 32'(bus.data_Di_sel), 1);
        check("wr_addr", 32'(bus.data_A), 4 * m_wptr);
        for (int k = 0; k < m_n; k++) begin
            e.tap_a  = 4 * k;
            e.data_a = 4 * ((m_wptr - k + m_n) % m_n);
            exp_q.push_back(e);
        end
        exp_last_q.push_back(int'(m_sent == m_l - 1));
        m_sent++;
        tick();
        bus.ss_tvalid = 1'b0;
        for (int c = 0; c < m_n + LAT; c++) begin
            if (c == poke_at) begin
                bus.ap_start    = 1'b1;
                bus.tap_num     = 6'd5;
                bus.data_length = 32'd1;
            end
            #1;
            if (c == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                m_done = 0;
                check("abort_idle", 32'(bus.ap_idle), 1);
                check("abort_ss_tready", 32'(bus.ss_tready), 0);
                check("abort_sm_tvalid", 32'(bus.sm_tvalid), 0);
                check("abort_done", 32'(bus.ap_done), 0);
                check("abort_mac_vld", 32'(bus.mac_vld), 0);
                check("abort_tap_en", 32'(bus.tap_EN), 0);
                exp_q.delete();
                exp_last_q.delete();
                return;
            end
            check("calc_ss_tready", 32'(bus.ss_tready), 0);
            check("calc_sm_tvalid", 32'(bus.sm_tvalid), 0);
            if (c < m_n) begin
                e = exp_q.pop_front();
                check("calc_tap_en", 32'(bus.tap_EN), 1);
                check("calc_data_en", 32'(bus.data_EN), 1);
                check("calc_tap_a", 32'(bus.tap_A), e.tap_a);
                check("calc_data_a", 32'(bus.data_A), e.data_a);
            end else begin
                check("drain_tap_en", 32'(bus.tap_EN), 0);
                check("drain_data_en", 32'(bus.data_EN), 0);
            end
            check("mac_vld", 32'(bus.mac_vld), (c >= LAT) ? 1 : 0);
            check("mac_first", 32'(bus.mac_first), (c == LAT) ? 1 : 0);
            tick();
            bus.ap_start = 1'b0;
        end
        #1;
        check("out_valid", 32'(bus.sm_tvalid), 1);
        check("out_last", 32'(bus.sm_tlast), exp_last_q.pop_front());
        check("out_ss_tready", 32'(bus.ss_tready), 0);
        check("out_mac_vld", 32'(bus.mac_vld), 0);
    endtask

    task automatic recv_beat(input int stall, input bit clr);
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", 32'(bus.sm_tvalid), 1);
            check("stall_ss_tready", 32'(bus.ss_tready), 0);
            check("stall_data_en", 32'(bus.data_EN), 0);
            check("stall_tap_en", 32'(bus.tap_EN), 0);
            tick();
        end
        bus.sm_tready = 1'b1;
        if (clr) bus.done_clr = 1'b1;
        #1;
        check("hs_valid", 32'(bus.sm_tvalid), 1);
        tick();
        bus.sm_tready = 1'b0;
        bus.done_clr  = 1'b0;
        m_wptr = (m_wptr + 1) % m_n;
        #1;
        if (m_sent == m_l) begin
            m_done = 1;
            check("end_idle", 32'(bus.ap_idle), 1);
            check("end_done", 32'(bus.ap_done), 1);
            check("end_lock", 32'(bus.cfg_lock), 0);
            check("end_valid", 32'(bus.sm_tvalid), 0);
        end else begin
            check("next_ready", 32'(bus.ss_tready), 1);
            check("next_valid", 32'(bus.sm_tvalid), 0);
        end
    endtask

    initial begin
        bus.ap_start    = 1'b0;
        bus.done_clr    = 1'b0;
        bus.tap_num     = '0;
        bus.data_length = '0;
        bus.ss_tvalid   = 1'b0;
        bus.sm_tready   = 1'b1;
        m_done          = 0;
        rst             = 1'b1;
        tick();
        tick();
        check("rst_idle", 32'(bus.ap_idle), 1);
        check("rst_done", 32'(bus.ap_done), 0);
        check("rst_lock", 32'(bus.cfg_lock), 0);
        check("rst_ss_tready", 32'(bus.ss_tready), 0);
        check("rst_sm_tvalid", 32'(bus.sm_tvalid), 0);
        check("rst_sm_tlast", 32'(bus.sm_tlast), 0);
        check("rst_tap_en", 32'(bus.tap_EN), 0);
        check("rst_data_en", 32'(bus.data_EN), 0);
        check("rst_data_we", 32'(bus.data_WE), 0);
        check("rst_mac_vld", 32'(bus.mac_vld), 0);
        check("rst_mac_first", 32'(bus.mac_first), 0);
        rst           = 1'b0;
        bus.sm_tready = 1'b0;

        // N=11, three outputs; ap_start ignored mid-CALC, stalled beat, early ready, clr vs set
        start_run(11, 3);
        run_init(1'b0);
        send_sample(-1, -1, 1'b0);
        recv_beat(0, 1'b0);
        send_sample(2, -1, 1'b0);
        recv_beat(5, 1'b0);
        send_sample(-1, -1, 1'b1);
        recv_beat(0, 1'b1);

        // zero-length run: INIT only; ap_start keeps ap_done, done_clr clears it
        start_run(4, 0);
        run_init(1'b1);

        // tap_num above the maximum clamps to 32
        start_run(40, 1);
        run_init(1'b0);
        send_sample(-1, -1, 1'b0);
        recv_beat(0, 1'b0);

        // single tap
        start_run(1, 2);
        run_init(1'b0);
        send_sample(-1, -1, 1'b0);
        recv_beat(0, 1'b0);
        send_sample(-1, -1, 1'b0);
        recv_beat(0, 1'b0);

        // reset during CALC of the second sample
        start_run(11, 3);
        run_init(1'b0);
        send_sample(-1, -1, 1'b0);
        recv_beat(0, 1'b0);
        send_sample(-1, 4, 1'b0);

        // tap_num=0 treated as one tap
        start_run(0, 0);
        run_init(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
